int_ack_master: RTL
===================

// Module: int_ack_master
// PURPOSE
//  CPU-side interrupt acknowledge master for the 8259A PIC: the receiving end of INT/INTA.
//  Synchronises the PIC INT line and, when interrupts are enabled, drives the 8086-mode
//  two-pulse INTA sequence. Samples the vector byte on the 2nd pulse and hands it to the
//  CPU core over a valid/ready interface. Sits between the PIC data bus and the core.
// PARAMETERS
//  PULSE_CYCLES  2  clocks inta_n is held low per pulse (>=1)
//  GAP_CYCLES    2  clocks inta_n is held high between pulse 1 and pulse 2 (>=1)
//  COOL_CYCLES   2  clocks after vector handshake before INT is re-evaluated (>=2)
// PORTS
//  clk         in   1  single system clock, rising edge
//  reset_n     in   1  asynchronous, active-low reset
//  int_req     in   1  INT from PIC; asynchronous, through a 2-flop synchroniser
//  int_enable  in   1  core interrupt-enable flag; sampled in IDLE only
//  data_bus    in   8  PIC data bus; carries vector during pulse 2
//  inta_n      out  1  interrupt acknowledge to PIC, active low, registered
//  vec_valid   out  1  vector available to core
//  vec_data    out  8  captured vector; stable while vec_valid=1
//  vec_ready   in   1  core accepts vector when vec_valid & vec_ready
//  busy        out  1  high whenever state != IDLE
// BEHAVIOUR
//  Reset (async assert, sync deassert use): state=IDLE, inta_n=1, vec_valid=0,
//   vec_data=8'h00, busy=0, counters=0, synchroniser flops=0. Mid-sequence reset aborts
//   immediately; inta_n returns high without waiting for a clock.
//  int_sync = 2nd synchroniser flop. Single down-counter, width $clog2(max param)+1.
//  FSM:
//   IDLE  : int_sync & int_enable -> P1 (load PULSE_CYCLES-1); else stay.
//   P1    : inta_n=0; count to 0 -> GAP (load GAP_CYCLES-1).
//   GAP   : inta_n=1; count to 0 -> P2 (load PULSE_CYCLES-1).
//   P2    : inta_n=0; on the count==0 edge capture data_bus into vec_data -> HOLD.
//   HOLD  : inta_n=1, vec_valid=1; on vec_valid & vec_ready -> COOL (load COOL_CYCLES-1).
//   COOL  : vec_valid=0; count to 0 -> IDLE.
//  inta_n and vec_valid are decoded from the next state and registered (no glitches).
//  Latency: int_req stable high before edge k (int_enable=1) -> int_sync=1 after edge k+1
//   -> inta_n low after edge k+2. Vector valid the edge after P2 ends.
//  Pulse shape (defaults): inta_n 1,0,0,1,1,0,0,1... exactly PULSE/GAP/PULSE cycles.
//  Once P1 is entered the sequence always completes, even if int_req or int_enable
//   drop (the PIC requires both pulses); vector is whatever data_bus held at capture.
//  data_bus is ignored outside the final P2 cycle; vec_data holds until next capture.
//  HOLD: no further pulses while the core stalls, regardless of int_req.
//  COOL: lets a deasserted INT propagate through the synchroniser; int_req still high
//   at COOL exit with int_enable=1 starts a new sequence directly from IDLE.
//  vec_ready outside HOLD is ignored. busy=1 in P1, GAP, P2, HOLD, COOL.
// TESTING
//  1 defaults, int_enable=1, int_req 0->1, data_bus=8'h48 in P2 -> inta_n low 2, high 2,
//    low 2 cycles; vec_valid=1, vec_data=8'h48 the cycle after; vec_ready=1 -> IDLE.
//  2 vec_ready held 0 for 5 cycles, int_req high -> vec_valid/vec_data stable, inta_n=1.
//  3 int_enable=0, int_req=1 for 10 cycles -> no pulse, busy=0; enable=1 -> inta_n low
//    on the next edge.
//  4 int_req drops in cycle 1 of P1 -> both pulses still issued, vector captured.
//  5 reset_n=0 during GAP -> inta_n=1, vec_valid=0, busy=0 without a clock edge;
//    after release with int_req=0 no pulse for 20 cycles.
//  6 data_bus=8'hFF in P1/GAP, 8'h20 on last P2 cycle, 8'h99 after -> vec_data=8'h20.

Source files
------------

// File: rtl/int_ack_master.sv
// CPU-side 8259A interrupt acknowledge master.
// Synchronises INT, issues the two-pulse INTA sequence and hands the vector to the core.
module int_ack_master #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2,
    parameter int COOL_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       int_req,
    input  logic       int_enable,
    input  logic [7:0] data_bus,
    output logic       inta_n,
    output logic       vec_valid,
    output logic [7:0] vec_data,
    input  logic       vec_ready,
    output logic       busy
);

    localparam int MAXP = (PULSE_CYCLES > GAP_CYCLES) ?
                          ((PULSE_CYCLES > COOL_CYCLES) ? PULSE_CYCLES : COOL_CYCLES) :
                          ((GAP_CYCLES > COOL_CYCLES) ? GAP_CYCLES : COOL_CYCLES);
    localparam int CW = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] COOL_LD  = CW'(COOL_CYCLES - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        P1,
        GAP,
        P2,
        HOLD,
        COOL
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [1:0]    sync;
    logic          int_sync;
    logic          capture;

    assign int_sync = sync[1];
    assign busy     = (state != IDLE);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                if (int_sync && int_enable) begin
                    state_next = P1;
                    cnt_next   = PULSE_LD;
                end
            end
            P1: begin
                if (cnt == '0) begin
                    state_next = GAP;
                    cnt_next   = GAP_LD;
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_next = P2;
                    cnt_next   = PULSE_LD;
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
            P2: begin
                if (cnt == '0) begin
                    state_next = HOLD;
                    capture    = 1'b1;
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
            HOLD: begin
                // vec_valid is always high here, so ready alone completes the handshake
                if (vec_ready) begin
                    state_next = COOL;
                    cnt_next   = COOL_LD;
                end
            end
            COOL: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sync      <= 2'b00;
            inta_n    <= 1'b1;
            vec_valid <= 1'b0;
            vec_data  <= 8'h00;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            sync      <= {sync[0], int_req};
            // outputs registered from next state so they never glitch
            inta_n    <= !((state_next == P1) || (state_next == P2));
            vec_valid <= (state_next == HOLD);
            if (capture) begin
                vec_data <= data_bus;
            end
        end
    end

endmodule
